// File: rtl/pipeline_defs.sv
// Shared widths, instruction field positions and in-flight tracker entry type
// for the decode/register-file stage.
package pipeline_defs;

  localparam int INST_WIDTH     = 32;
  localparam int DATAPATH_WIDTH = 64;
  localparam int REGFILE_ADDR   = 3;
  localparam int NUM_REGS       = 1 << REGFILE_ADDR;
  localparam int MEM_ADDR_WIDTH = 16;
  localparam int INFLIGHT_DEPTH = 2;

  localparam int WREGEN_BIT = 31;
  localparam int WMEMEN_BIT = 30;
  localparam int RS1_MSB    = 29;
  localparam int RS1_LSB    = 27;
  localparam int RS2_MSB    = 26;
  localparam int RS2_LSB    = 24;
  localparam int RD_MSB     = 23;
  localparam int RD_LSB     = 21;

  typedef struct packed {
    logic                    v;
    logic [REGFILE_ADDR-1:0] addr;
  } inflight_t;

endpackage

// File: rtl/regfile_8x64.sv
// 8 x 64 register file: R0 hard-wired to zero, one write port, two
// combinational read ports with write-through bypass from the write port.
module regfile_8x64
  import pipeline_defs::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_en,
  input  logic [REGFILE_ADDR-1:0]   wb_addr,
  input  logic [DATAPATH_WIDTH-1:0] wb_data,
  input  logic [REGFILE_ADDR-1:0]   rs1_addr,
  input  logic [REGFILE_ADDR-1:0]   rs2_addr,
  output logic [DATAPATH_WIDTH-1:0] rs1_data,
  output logic [DATAPATH_WIDTH-1:0] rs2_data
);

  logic [DATAPATH_WIDTH-1:0] regs [NUM_REGS];

  // Reset takes priority over a coincident write-back; R0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      if (wb_en && wb_addr == rs1_addr) rs1_data = wb_data;
      else                              rs1_data = regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      if (wb_en && wb_addr == rs2_addr) rs2_data = wb_data;
      else                              rs2_data = regs[rs2_addr];
    end
  end

endmodule

// File: rtl/decode_regfile_stage.sv
// Decode stage: field decode, register-file read, and a RAW interlock that
// stalls fetch while a source register has a write still in flight.
module decode_regfile_stage
  import pipeline_defs::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      inst_valid,
  input  logic [INST_WIDTH-1:0]     inst,
  input  logic                      wb_en,
  input  logic [REGFILE_ADDR-1:0]   wb_addr,
  input  logic [DATAPATH_WIDTH-1:0] wb_data,
  output logic                      stall,
  output logic                      WRegEn_dec,
  output logic                      WMemEn_dec,
  output logic [DATAPATH_WIDTH-1:0] R1out_dec,
  output logic [DATAPATH_WIDTH-1:0] R2out_dec,
  output logic [REGFILE_ADDR-1:0]   WReg1_dec
);

  logic                      wreg_en;
  logic                      wmem_en;
  logic [REGFILE_ADDR-1:0]   rs1;
  logic [REGFILE_ADDR-1:0]   rs2;
  logic [REGFILE_ADDR-1:0]   rd;
  logic [DATAPATH_WIDTH-1:0] rs1_data;
  logic [DATAPATH_WIDTH-1:0] rs2_data;
  logic                      rs1_busy;
  logic                      rs2_busy;
  logic                      hazard;
  logic                      issue;
  logic                      unused_inst_bits;
  inflight_t                 tracker [INFLIGHT_DEPTH];

  assign wreg_en          = inst[WREGEN_BIT];
  assign wmem_en          = inst[WMEMEN_BIT];
  assign rs1              = inst[RS1_MSB:RS1_LSB];
  assign rs2              = inst[RS2_MSB:RS2_LSB];
  assign rd               = inst[RD_MSB:RD_LSB];
  assign unused_inst_bits = ^inst[RD_LSB-1:0];

  regfile_8x64 u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
      if (tracker[i].v && tracker[i].addr == rs1) rs1_busy = 1'b1;
      if (tracker[i].v && tracker[i].addr == rs2) rs2_busy = 1'b1;
    end
  end

  assign hazard = inst_valid && ((rs1 != '0 && rs1_busy) || (rs2 != '0 && rs2_busy));
  assign issue  = inst_valid && !hazard;

  // Entry 0 is the instruction now entering execute; bubbles shift in as invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < INFLIGHT_DEPTH; i++) tracker[i] <= '0;
    end else if (en) begin
      tracker[0].v    <= issue && wreg_en && rd != '0;
      tracker[0].addr <= rd;
      for (int i = 1; i < INFLIGHT_DEPTH; i++) tracker[i] <= tracker[i-1];
    end
  end

  always_comb begin
    stall      = 1'b0;
    WRegEn_dec = 1'b0;
    WMemEn_dec = 1'b0;
    WReg1_dec  = '0;
    R1out_dec  = '0;
    R2out_dec  = '0;
    if (!reset) begin
      stall      = hazard;
      WRegEn_dec = issue && wreg_en;
      WMemEn_dec = issue && wmem_en;
      WReg1_dec  = issue ? rd : '0;
      R1out_dec  = rs1_data;
      R2out_dec  = rs2_data;
    end
  end

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Self-checking bench: directed vectors with literal expectations plus a
// per-cycle compare against a register-scoreboard model of the stage.
module tb_decode_regfile_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        en;
  logic        inst_valid;
  logic [31:0] inst;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [63:0] wb_data;
  logic        stall;
  logic        WRegEn_dec;
  logic        WMemEn_dec;
  logic [63:0] R1out_dec;
  logic [63:0] R2out_dec;
  logic [2:0]  WReg1_dec;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] m_regs [8];
  int          busy_until [8];
  int          adv = 0;

  decode_regfile_stage dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .inst_valid (inst_valid),
    .inst       (inst),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall      (stall),
    .WRegEn_dec (WRegEn_dec),
    .WMemEn_dec (WMemEn_dec),
    .R1out_dec  (R1out_dec),
    .R2out_dec  (R2out_dec),
    .WReg1_dec  (WReg1_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic wr, input logic wm, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [2:0] d);
    return {wr, wm, s1, s2, d, 21'h15A5A};
  endfunction

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic e, input logic v, input logic [31:0] i,
                                input logic we, input logic [2:0] wa, input logic [63:0] wd);
    @(negedge clk);
    reset = rst; en = e; inst_valid = v; inst = i;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #3;
  endtask

  function automatic logic [63:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return 64'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic model_busy(input logic [2:0] a);
    return a != 3'd0 && busy_until[a] >= adv;
  endfunction

  // Model: a write issued at advance count a blocks its register through a+DEPTH.
  always @(posedge clk) begin
    logic [2:0] m_rd;
    logic       m_haz;
    m_rd  = inst[23:21];
    m_haz = inst_valid && (model_busy(inst[29:27]) || model_busy(inst[26:24]));
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        m_regs[k]     <= 64'd0;
        busy_until[k] <= -100;
      end
    end else begin
      if (wb_en && wb_addr != 3'd0) m_regs[wb_addr] <= wb_data;
      if (en) begin
        adv <= adv + 1;
        if (inst_valid && !m_haz && inst[31] && m_rd != 3'd0) busy_until[m_rd] <= adv + DEPTH;
      end
    end
  end

  always begin
    logic        e_haz;
    logic        e_issue;
    @(negedge clk);
    #2;
    e_haz   = inst_valid && (model_busy(inst[29:27]) || model_busy(inst[26:24]));
    e_issue = inst_valid && !e_haz;
    if (reset) begin
      check_output("model_stall",  {63'd0, stall}, 64'd0);
      check_output("model_wregen", {63'd0, WRegEn_dec}, 64'd0);
      check_output("model_wmemen", {63'd0, WMemEn_dec}, 64'd0);
      check_output("model_wreg1",  {61'd0, WReg1_dec}, 64'd0);
      check_output("model_r1",     R1out_dec, 64'd0);
      check_output("model_r2",     R2out_dec, 64'd0);
    end else begin
      check_output("model_stall",  {63'd0, stall}, {63'd0, e_haz});
      check_output("model_wregen", {63'd0, WRegEn_dec}, {63'd0, e_issue && inst[31]});
      check_output("model_wmemen", {63'd0, WMemEn_dec}, {63'd0, e_issue && inst[30]});
      check_output("model_wreg1",  {61'd0, WReg1_dec}, e_issue ? {61'd0, inst[23:21]} : 64'd0);
      check_output("model_r1",     R1out_dec, model_read(inst[29:27]));
      check_output("model_r2",     R2out_dec, model_read(inst[26:24]));
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      m_regs[k]     = 64'd0;
      busy_until[k] = -100;
    end
    reset = 1'b1; en = 1'b1; inst_valid = 1'b0; inst = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset, then read R3/R5 as zero
    apply_stimulus(1, 1, 1, mk(0, 0, 3, 5, 0), 0, 0, 0);
    check_output("rst_stall", {63'd0, stall}, 64'd0);
    check_output("rst_r1", R1out_dec, 64'd0);
    apply_stimulus(0, 1, 1, mk(0, 0, 3, 5, 0), 0, 0, 0);
    check_output("read_r1_zero", R1out_dec, 64'd0);
    check_output("read_r2_zero", R2out_dec, 64'd0);
    check_output("read_stall", {63'd0, stall}, 64'd0);

    // Write R3, attempt R0 write, then read back
    apply_stimulus(0, 1, 0, '0, 1, 3, 64'h1234);
    apply_stimulus(0, 1, 0, '0, 1, 0, 64'hFF);
    apply_stimulus(0, 1, 1, mk(0, 0, 3, 0, 0), 0, 0, 0);
    check_output("wr_r3", R1out_dec, 64'h1234);
    check_output("r0_zero", R2out_dec, 64'd0);

    // Same-cycle write-back bypass
    apply_stimulus(0, 1, 1, mk(0, 0, 0, 6, 0), 1, 6, 64'hDEAD);
    check_output("bypass_r2", R2out_dec, 64'hDEAD);

    // RAW interlock: producer rd=2, consumer rs1=2 stalls two cycles
    apply_stimulus(0, 1, 1, mk(1, 0, 0, 0, 2), 0, 0, 0);
    check_output("prod_wregen", {63'd0, WRegEn_dec}, 64'd1);
    check_output("prod_wreg1", {61'd0, WReg1_dec}, 64'd2);
    apply_stimulus(0, 1, 1, mk(1, 1, 2, 0, 4), 0, 0, 0);
    check_output("raw_stall1", {63'd0, stall}, 64'd1);
    check_output("raw_bubble_wreg", {63'd0, WRegEn_dec}, 64'd0);
    check_output("raw_bubble_wmem", {63'd0, WMemEn_dec}, 64'd0);
    apply_stimulus(0, 1, 1, mk(1, 1, 2, 0, 4), 0, 0, 0);
    check_output("raw_stall2", {63'd0, stall}, 64'd1);
    apply_stimulus(0, 1, 1, mk(1, 1, 2, 0, 4), 1, 2, 64'h77);
    check_output("raw_release", {63'd0, stall}, 64'd0);
    check_output("raw_r1", R1out_dec, 64'h77);
    check_output("raw_wreg1", {61'd0, WReg1_dec}, 64'd4);
    for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 0, '0, 0, 0, 0);

    // No false hazards from rd=0 producer or a non-writing producer
    apply_stimulus(0, 1, 1, mk(1, 0, 0, 0, 0), 0, 0, 0);
    apply_stimulus(0, 1, 1, mk(0, 0, 0, 0, 1), 0, 0, 0);
    check_output("rd0_nostall", {63'd0, stall}, 64'd0);
    apply_stimulus(0, 1, 1, mk(0, 0, 0, 0, 3), 0, 0, 0);
    apply_stimulus(0, 1, 1, mk(0, 0, 3, 0, 0), 0, 0, 0);
    check_output("nowr_nostall", {63'd0, stall}, 64'd0);
    check_output("nowr_r1", R1out_dec, 64'h1234);
    for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 0, '0, 0, 0, 0);

    // Freeze during a hazard, then reset mid-stall
    apply_stimulus(0, 1, 1, mk(1, 0, 0, 0, 5), 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 1, mk(0, 0, 3, 5, 0), 0, 0, 0);
      check_output("freeze_stall", {63'd0, stall}, 64'd1);
    end
    apply_stimulus(0, 1, 1, mk(0, 0, 3, 5, 0), 0, 0, 0);
    check_output("held_stall", {63'd0, stall}, 64'd1);
    check_output("held_r1", R1out_dec, 64'h1234);
    apply_stimulus(1, 1, 1, mk(0, 0, 3, 5, 0), 1, 1, 64'hAB);
    check_output("midrst_stall", {63'd0, stall}, 64'd0);
    apply_stimulus(0, 1, 1, mk(0, 0, 3, 5, 0), 0, 0, 0);
    check_output("postrst_stall", {63'd0, stall}, 64'd0);
    check_output("postrst_r1", R1out_dec, 64'd0);
    apply_stimulus(0, 1, 1, mk(0, 0, 1, 3, 0), 0, 0, 0);
    check_output("rst_wins_wb", R1out_dec, 64'd0);
    apply_stimulus(0, 1, 0, '0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
